trap_ctrl: RTL



---
 rtl/trap_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer between commit and the CSR file: arbitrates trap/mret events,
// strobes the CSR update, then hands one redirect PC to fetch.
module trap_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DATA_WIDTH'(2),
  parameter logic [DATA_WIDTH-1:0] CAUSE_BREAK   = DATA_WIDTH'(3),
  parameter logic [DATA_WIDTH-1:0] CAUSE_ECALL   = DATA_WIDTH'(11),
  parameter logic [DATA_WIDTH-1:0] CAUSE_TIMER   = DATA_WIDTH'(32'h8000_0007)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_ecall,
  input  logic                  ex_ebreak,
  input  logic                  ex_illegal,
  input  logic                  ex_mret,
  input  logic                  timer_irq,
  input  logic                  mstatus_mie,
  output logic                  flush,
  output logic                  intr,
  output logic [DATA_WIDTH-1:0] intr_NO,
  output logic [DATA_WIDTH-1:0] intr_epc,
  output logic                  mret,
  input  logic [DATA_WIDTH-1:0] intr_mtvec,
  input  logic [DATA_WIDTH-1:0] mret_mepc,
  output logic                  redir_valid,
  output logic [DATA_WIDTH-1:0] redir_pc,
  input  logic                  redir_ready,
  output logic [DATA_WIDTH-1:0] trap_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    MRET  = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t                state;
  logic                  irq_c;
  logic                  accept_c;
  logic                  take_trap_c;
  logic                  take_mret_c;
  logic [DATA_WIDTH-1:0] cause_c;

  assign irq_c       = timer_irq & mstatus_mie;
  assign accept_c    = ex_valid & (state == IDLE);
  assign take_trap_c = irq_c | ex_illegal | ex_ebreak | ex_ecall;
  assign take_mret_c = ex_mret & ~take_trap_c;

  // Younger instructions are killed in the same cycle the event is accepted.
  assign flush = accept_c & (take_trap_c | take_mret_c);

  // Priority encode the trap cause; interrupt wins over any instruction event.
  always_comb begin
    cause_c = CAUSE_ECALL;
    if (irq_c)           cause_c = CAUSE_TIMER;
    else if (ex_illegal) cause_c = CAUSE_ILLEGAL;
    else if (ex_ebreak)  cause_c = CAUSE_BREAK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ex_ready    <= 1'b1;
      intr        <= 1'b0;
      intr_NO     <= '0;
      intr_epc    <= '0;
      mret        <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      trap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c && take_trap_c) begin
            intr_NO  <= cause_c;
            intr_epc <= ex_pc;
            intr     <= 1'b1;
            ex_ready <= 1'b0;
            state    <= TRAP;
          end else if (accept_c && take_mret_c) begin
            mret     <= 1'b1;
            ex_ready <= 1'b0;
            state    <= MRET;
          end
        end
        TRAP: begin
          intr        <= 1'b0;
          // Direct mode only: mode bits of mtvec are dropped.
          redir_pc    <= {intr_mtvec[DATA_WIDTH-1:2], 2'b00};
          redir_valid <= 1'b1;
          trap_cnt    <= trap_cnt + DATA_WIDTH'(1);
          state       <= REDIR;
        end
        MRET: begin
          mret        <= 1'b0;
          redir_pc    <= mret_mepc;
          redir_valid <= 1'b1;
          state       <= REDIR;
        end
        REDIR: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            ex_ready    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          intr        <= 1'b0;
          mret        <= 1'b0;
          redir_valid <= 1'b0;
          ex_ready    <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
